// File: rtl/seq_multiplier_32.sv
// Multi-cycle 32x32->64 shift-add multiplier (MULT/MULTU) with start/busy/done handshake.
// Each iteration adds the multiplicand into the upper partial product through a 32-bit CLA.

module cla4 (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);
    logic [3:0] g, p;
    logic [4:0] c;

    assign g    = x & y;
    assign p    = x ^ y;
    assign c[0] = ci;
    assign c[1] = g[0] | (p[0] & ci);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & ci);
    assign s    = p ^ c[3:0];
    assign co   = c[4];
endmodule

module cla_adder_32 (
    input  logic [31:0] x,
    input  logic [31:0] y,
    input  logic        ci,
    output logic [31:0] s,
    output logic        co
);
    logic [8:0] c;

    assign c[0] = ci;
    for (genvar gi = 0; gi < 8; gi++) begin : g_blk
        cla4 u_cla4 (
            .x  (x[4*gi +: 4]),
            .y  (y[4*gi +: 4]),
            .ci (c[gi]),
            .s  (s[4*gi +: 4]),
            .co (c[gi+1])
        );
    end
    assign co = c[8];
endmodule

module seq_multiplier_32 #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t             state_q, state_d;
    logic [4:0]         cnt_q, cnt_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic               neg_q, neg_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

    logic [WIDTH-1:0]   mag_a, mag_b, addend, sum;
    logic               cout;
    logic [2*WIDTH-1:0] result;

    assign mag_a  = (signed_op && a[WIDTH-1]) ? (~a + 1'b1) : a;
    assign mag_b  = (signed_op && b[WIDTH-1]) ? (~b + 1'b1) : b;
    assign addend = prod_q[0] ? mcand_q : '0;
    assign result = neg_q ? (~prod_q + 1'b1) : prod_q;

    cla_adder_32 u_add (
        .x  (prod_q[2*WIDTH-1:WIDTH]),
        .y  (addend),
        .ci (1'b0),
        .s  (sum),
        .co (cout)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mcand_d = mcand_q;
        neg_d   = neg_q;
        prod_d  = prod_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE, DONE: begin
                if (DONE == state_q) state_d = IDLE;
                if (start) begin
                    mcand_d = mag_a;
                    neg_d   = signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                    prod_d  = {{WIDTH{1'b0}}, mag_b};
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // {cout,sum,P_lo}>>1: the adder carry lands in bit 63, bit 64 is always 0
                prod_d = {cout, sum, prod_q[WIDTH-1:1]};
                cnt_d  = cnt_q + 5'd1;
                if (cnt_q == 5'(ITER-1)) state_d = FIX;
            end
            FIX: begin
                hi_d    = result[2*WIDTH-1:WIDTH];
                lo_d    = result[WIDTH-1:0];
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mcand_q <= '0;
            neg_q   <= 1'b0;
            prod_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mcand_q <= mcand_d;
            neg_q   <= neg_d;
            prod_q  <= prod_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = (state_q == RUN) || (state_q == FIX);
    assign done = (state_q == DONE);
    assign hi   = hi_q;
    assign lo   = lo_q;
endmodule
